div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Multi-cycle 32-bit radix-2 restoring divider serving the EX stage for DIV/DIVU.
//   EX issues a start request with the operands it receives from the ID/EX register.
//   The divider answers with {remainder, quotient} and a ready strobe.
//   While busy, EX holds the pipeline via its stall request; annul cancels an in-flight divide.
// PARAMETERS
//   DATA_W   32   operand width; result_o is 2*DATA_W; iteration count = DATA_W
// PORTS
//   clk            in   1         clock
//   rst            in   1         reset, synchronous, active-high
//   signed_div_i   in   1         1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   opdata1_i      in   DATA_W    dividend; sampled with start
//   opdata2_i      in   DATA_W    divisor; sampled with start
//   start_i        in   1         divide request; held high by EX until ready_o seen
//   annul_i        in   1         cancel current/pending divide (flush, exception)
//   result_o       out  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}
//   ready_o        out  1         result valid
//   div_zero_o     out  1         divisor was zero (only with DIV_ZERO_FLAG_EN)
// BEHAVIOUR
//   - Reset: state=FREE, cnt=0, result_o=0, ready_o=0, div_zero_o=0; aborts any divide in progress.
//   - All outputs registered; all state changes on posedge clk.
//   - States: FREE, BYZERO, ON, END.
//   - FREE:
//     - start_i && !annul_i && opdata2_i==0 -> BYZERO.
//     - start_i && !annul_i && opdata2_i!=0 -> ON, cnt=0; latch operands.
//     - Otherwise stay; ready_o=0, result_o=0.
//   - Operand latch (signed_div_i=1): negative operands replaced by two's-complement magnitude.
//     Latch the original sign bits and signed_div_i.
//   - BYZERO -> END with result_o=0.
//   - ON: one restoring step per cycle on a 2*DATA_W+1 working register.
//     - Trial subtract of the divisor from the upper half.
//     - Non-negative: keep difference, shift in quotient bit 1; negative: shift, bit 0.
//     - cnt increments; after the DATA_W-th step -> END.
//     - annul_i=1 in ON -> FREE next edge; no result, ready_o stays 0.
//   - Entering END, sign fixup (signed mode only):
//     - Quotient negated if dividend sign != divisor sign.
//     - Remainder negated if dividend negative.
//     - Then result_o loaded and ready_o=1.
//   - END: hold result_o and ready_o while start_i=1.
//     start_i=0 -> FREE; result_o=0, ready_o=0 at that edge.
//   - Latency (start sampled at edge E0):
//     - Nonzero divisor: ready_o high after edge E(DATA_W+1) (33 edges for DATA_W=32).
//     - Zero divisor: ready_o high after E2.
//   - Simultaneous events:
//     - annul_i beats start_i in FREE.
//     - annul_i in BYZERO or END -> FREE.
//     - rst beats everything.
//   - Overflow 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0 (natural wrap, no trap).
// CONFIGURATION
//   DIV_ZERO_FLAG_EN defined:
//     - div_zero_o=1 together with ready_o when the divide came via BYZERO.
//     - Otherwise div_zero_o=0; cleared on return to FREE.
//   DIV_ZERO_FLAG_EN undefined:
//     - div_zero_o tied to 0.
//     - Divide-by-zero still returns result 0 with normal ready_o.
// TESTING
//   1. Unsigned 100/7: start, 33 edges -> ready_o=1, result_o=0x00000002_0000000E; held until start_i drops.
//   2. Signed -100/7 (0xFFFFFF9C/7) -> result_o=0xFFFFFFFE_FFFFFFF2; signed 100/-7 -> 0x00000002_FFFFFFF2.
//   3. Divide by zero, 5/0 -> ready_o after 2 edges, result_o=0; with DIV_ZERO_FLAG_EN div_zero_o=1.
//   4. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF; signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
//   5. annul_i pulsed at ON step 10 -> FREE next edge, ready_o never asserts.
//      A following 9/3 completes -> 0x00000000_00000003.
//   6. rst asserted mid-ON -> next cycle ready_o=0, result_o=0, FREE; a fresh start is accepted immediately.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX; result is {remainder, quotient}.
// Optional build macro DIV_ZERO_FLAG_EN drives div_zero_o alongside ready_o for divide-by-zero.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  div_zero_o,
  output logic [1:0]            dbg_state
);

  // Handshake: start_i is a level request held by EX; ready_o marks result_o valid and
  // both stay up until start_i drops, which returns the unit to FREE with outputs cleared.
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic                neg_q, neg_r;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W:0]   shifted, step_next;
  logic [DATA_W+1:0]   diff;
  logic [DATA_W-1:0]   q_raw, r_raw, q_fix, r_fix;

  assign dbg_state = state;

  always_comb begin
    a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  // One restoring step: shift, trial-subtract from the upper half, keep only if no borrow.
  always_comb begin
    shifted   = {work[2*DATA_W-1:0], 1'b0};
    diff      = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, divisor};
    step_next = diff[DATA_W+1] ? shifted
                               : {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
  end

  always_comb begin
    q_raw = work[DATA_W-1:0];
    r_raw = work[2*DATA_W-1:DATA_W];
    q_fix = neg_q ? -q_raw : q_raw;
    r_fix = neg_r ? -r_raw : r_raw;
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE:   if (start_i && !annul_i) state_next = (opdata2_i == '0) ? BYZERO : ON;
      BYZERO: state_next = annul_i ? FREE : END;
      ON: begin
        if (annul_i)                          state_next = FREE;
        else if (cnt == CNT_W'(DATA_W - 1))   state_next = END;
      end
      END:    if (annul_i || !start_i) state_next = FREE;
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_next;
  end

`ifdef DIV_ZERO_FLAG_EN
  logic zero_flag;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      zero_flag  <= 1'b0;
      div_zero_o <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_o <= 1'b0;
`endif
          if (start_i && !annul_i) begin
            cnt <= '0;
`ifdef DIV_ZERO_FLAG_EN
            zero_flag <= (opdata2_i == '0);
`endif
            if (opdata2_i == '0) begin
              // Cleared working state makes the END load produce an all-zero result.
              work  <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              work    <= {{(DATA_W+1){1'b0}}, a_mag};
              divisor <= b_mag;
              neg_q   <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_r   <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end
        ON: begin
          work <= step_next;
          cnt  <= cnt + 1'b1;
        end
        END: begin
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
          end else if (!ready_o) begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= zero_flag;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef DIV_ZERO_FLAG_EN
  assign div_zero_o = 1'b0;
`endif

endmodule
